// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART serial front end.
// Receiver parity support is compiled in only with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEF_CLK_DIV = 2604;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: clear/enable bit-period counter with half and full strobes.
// Shared by the UART receiver and transmitter.
module uart_baud_cnt #(
  parameter int CLK_DIV = uart_pkg::DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter restarts at 0 the cycle after a clear, hence the -1 offsets.
  assign half_tick = en && (cnt_q == CW'(CLK_DIV / 2 - 1));
  assign full_tick = en && (cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with framing/parity/overrun flags.
// Define UART_RX_PARITY_EN to compile in the parity state and check.
module uart_rx_cfg #(
  parameter int CLK_DIV   = uart_pkg::DEF_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = uart_pkg::PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rx_rdy,
  output logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  import uart_pkg::rx_state_t;
  import uart_pkg::IDLE;
  import uart_pkg::START;
  import uart_pkg::DATA;
  import uart_pkg::STOP;
  import uart_pkg::PAR_NONE;

  localparam int BW = 4;

`ifdef UART_RX_PARITY_EN
  localparam bit        PAR_BUILD = 1'b1;
  localparam rx_state_t PAR_ST    = uart_pkg::PARITY;
  localparam bit        PAR_ODD_M = (PARITY == uart_pkg::PAR_ODD);
`else
  localparam bit        PAR_BUILD = 1'b0;
  localparam rx_state_t PAR_ST    = STOP;
`endif
  localparam bit        PAR_ON    = PAR_BUILD && (PARITY != PAR_NONE);
  localparam rx_state_t POST_DATA = PAR_ON ? PAR_ST : STOP;

  logic rx_meta_q, rx_s_q, rx_prev_q;

  rx_state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic ferr_q, ferr_d;
  logic rx_rdy_q, rx_rdy_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
`endif

  logic cnt_clr, cnt_en, half_tick, full_tick;

  assign cnt_en = (state_q != IDLE);

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    rx_data_d   = rx_data_q;
    rx_rdy_d    = rx_rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif
    cnt_clr = 1'b0;

    if (clr_rx_rdy) begin
      rx_rdy_d    = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_clr = 1'b1;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_d = 1'b0;
`endif
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          cnt_clr = 1'b1;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = POST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      uart_pkg::PARITY: begin
        if (full_tick) begin
          cnt_clr = 1'b1;
          par_d   = (^shift_q) ^ rx_s_q ^ PAR_ODD_M;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (full_tick) begin
          cnt_clr = 1'b1;
          ferr_d  = ferr_q || !rx_s_q;
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            // Commit overrides a same-cycle clear; that clear consumes the old frame.
            state_d     = IDLE;
            rx_data_d   = shift_q;
            rx_rdy_d    = 1'b1;
            frame_err_d = ferr_q || !rx_s_q;
            overrun_d   = rx_rdy_q && !clr_rx_rdy;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_q;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= RX;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      rx_data_q   <= rx_data_d;
      rx_rdy_q    <= rx_rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_rdy    = rx_rdy_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: vector table plus scoreboard bench for uart_rx_cfg.
// Parity expectations follow UART_RX_PARITY_EN.
module tb_uart_rx_cfg;

  localparam int DIV = 16;

`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  logic clr = 1'b0;
  int   rx_sel = 0;

  logic rx_a, rx_p, rx_7;
  logic clr_a, clr_p, clr_7;
  logic rdy_a, fe_a, pe_a, ov_a;
  logic rdy_p, fe_p, pe_p, ov_p;
  logic rdy_7, fe_7, pe_7, ov_7;
  logic [7:0] d_a, d_p;
  logic [6:0] d_7;

  logic       cur_rdy, cur_fe, cur_pe, cur_ov;
  logic [8:0] cur_data;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    int         pbm;
    logic       stop_val;
    logic       clr_after;
    logic       fe;
    logic       pe;
    logic       ov;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  assign rx_a  = (rx_sel == 0) ? rx_line : 1'b1;
  assign rx_p  = (rx_sel == 1) ? rx_line : 1'b1;
  assign rx_7  = (rx_sel == 2) ? rx_line : 1'b1;
  assign clr_a = clr && (rx_sel == 0);
  assign clr_p = clr && (rx_sel == 1);
  assign clr_7 = clr && (rx_sel == 2);

  uart_rx_cfg #(
    .CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1),
    .PARITY(uart_pkg::PAR_NONE)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_rx_rdy(clr_a),
    .rx_rdy(rdy_a), .rx_data(d_a), .frame_err(fe_a),
    .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_cfg #(
    .CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1),
    .PARITY(uart_pkg::PAR_EVEN)
  ) u_p (
    .clk(clk), .rst_n(rst_n), .RX(rx_p), .clr_rx_rdy(clr_p),
    .rx_rdy(rdy_p), .rx_data(d_p), .frame_err(fe_p),
    .parity_err(pe_p), .overrun(ov_p)
  );

  uart_rx_cfg #(
    .CLK_DIV(DIV), .DATA_BITS(7), .STOP_BITS(2),
    .PARITY(uart_pkg::PAR_NONE)
  ) u_7 (
    .clk(clk), .rst_n(rst_n), .RX(rx_7), .clr_rx_rdy(clr_7),
    .rx_rdy(rdy_7), .rx_data(d_7), .frame_err(fe_7),
    .parity_err(pe_7), .overrun(ov_7)
  );

  always #5 clk = ~clk;

  always_comb begin
    cur_rdy  = rdy_a;
    cur_fe   = fe_a;
    cur_pe   = pe_a;
    cur_ov   = ov_a;
    cur_data = {1'b0, d_a};
    if (rx_sel == 1) begin
      cur_rdy  = rdy_p;
      cur_fe   = fe_p;
      cur_pe   = pe_p;
      cur_ov   = ov_p;
      cur_data = {1'b0, d_p};
    end else if (rx_sel == 2) begin
      cur_rdy  = rdy_7;
      cur_fe   = fe_7;
      cur_pe   = pe_7;
      cur_ov   = ov_7;
      cur_data = {2'b0, d_7};
    end
  end

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data,
                            input int db, input int pbm,
                            input int nstop, input logic stop_val);
    rx_sel = sel;
    send_bit(1'b0);
    for (int i = 0; i < db; i++) send_bit(data[i]);
    if (pbm != 0) send_bit(pbm == 2);
    for (int i = 0; i < nstop; i++) send_bit(stop_val);
    rx_line = 1'b1;
  endtask

  task automatic wait_rdy(input int bound, input string nm);
    int k = 0;
    while (cur_rdy !== 1'b1 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (cur_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: rx_rdy=%b after %0d cycles, expected 1",
               nm, cur_rdy, bound);
    end
  endtask

  task automatic check_sb(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, expected an entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_rdy"}, 9'(cur_rdy), 9'h1);
      chk({nm, "_data"}, cur_data, e.data);
      chk({nm, "_fe"}, 9'(cur_fe), 9'(e.fe));
      chk({nm, "_pe"}, 9'(cur_pe), 9'(e.pe));
      chk({nm, "_ov"}, 9'(cur_ov), 9'(e.ov));
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic clr_check(input string nm);
    pulse_clr();
    chk({nm, "_rdy"}, 9'(cur_rdy), 9'h0);
    chk({nm, "_flags"}, 9'({cur_fe, cur_pe, cur_ov}), 9'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = vec_t'{0, 9'h03C, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = vec_t'{0, 9'h011, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = vec_t'{0, 9'h022, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = vec_t'{1, 9'h007, 1, 1'b1, 1'b1, !PEN, PEN, 1'b0};
    tbl[4] = vec_t'{1, 9'h007, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = vec_t'{1, 9'h003, 1, 1'b1, 1'b1, !PEN, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 9'({rdy_a, rdy_p, rdy_7}), 9'h0);
    chk("rst_data_a", 9'(d_a), 9'h0);
    chk("rst_data_7", 9'(d_7), 9'h0);
    chk("rst_flags_a", 9'({fe_a, pe_a, ov_a}), 9'h0);
    chk("rst_flags_p", 9'({fe_p, pe_p, ov_p}), 9'h0);
    chk("rst_flags_7", 9'({fe_7, pe_7, ov_7}), 9'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8N1 0xA5: rx_rdy must rise on exactly the 155th edge after RX falls.
    rx_sel = 0;
    sb.push_back(exp_t'{9'h0A5, 1'b0, 1'b0, 1'b0});
    fork
      send_frame(0, 9'h0A5, 8, 0, 1, 1'b1);
      begin
        repeat (DIV / 2 + 9 * DIV + 2) @(posedge clk);
        #1;
        chk("a5_early", 9'(rdy_a), 9'h0);
        @(posedge clk);
        #1;
        chk("a5_rise", 9'(rdy_a), 9'h1);
      end
    join
    check_sb("a5");
    clr_check("a5_clr");

    // False start: 4-cycle low pulse, then a clean frame must still align.
    rx_line = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    #1;
    chk("glitch_rdy", 9'(rdy_a), 9'h0);
    sb.push_back(exp_t'{9'h05A, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h05A, 8, 0, 1, 1'b1);
    wait_rdy(2 * DIV, "glitch_next");
    check_sb("glitch_next");
    clr_check("glitch_clr");

    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_t'{tbl[i].data, tbl[i].fe, tbl[i].pe, tbl[i].ov});
      send_frame(tbl[i].sel, tbl[i].data, 8, tbl[i].pbm, 1, tbl[i].stop_val);
      wait_rdy(2 * DIV, $sformatf("vec%0d_wait", i));
      check_sb($sformatf("vec%0d", i));
      if (tbl[i].clr_after) clr_check($sformatf("vec%0d_clr", i));
      if (i == 0) chk("clr_keeps_data", cur_data, 9'h03C);
      if (i == 2) begin
        sb.push_back(exp_t'{9'h033, 1'b0, 1'b0, 1'b0});
        fork
          send_frame(0, 9'h033, 8, 0, 1, 1'b1);
          begin
            repeat (DIV / 2 + 9 * DIV + 2) @(posedge clk);
            #1;
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
          end
        join
        check_sb("clr_vs_commit");
        clr_check("clr_vs_commit_clr");
      end
    end

    rx_sel = 2;
    sb.push_back(exp_t'{9'h055, 1'b0, 1'b0, 1'b0});
    sb.push_back(exp_t'{9'h02A, 1'b0, 1'b0, 1'b0});
    fork
      begin
        send_frame(2, 9'h055, 7, 0, 2, 1'b1);
        send_frame(2, 9'h02A, 7, 0, 2, 1'b1);
      end
      begin
        wait_rdy(12 * DIV, "b2b_first_wait");
        check_sb("b2b_first");
        pulse_clr();
        wait_rdy(12 * DIV, "b2b_second_wait");
        check_sb("b2b_second");
      end
    join
    clr_check("b2b_clr");

    sb.push_back(exp_t'{9'h055, 1'b0, 1'b0, 1'b0});
    fork
      begin
        send_frame(2, 9'h055, 7, 0, 2, 1'b1);
        send_frame(2, 9'h02A, 7, 0, 2, 1'b1);
      end
      begin
        wait_rdy(12 * DIV, "rst_first_wait");
        check_sb("rst_first");
        repeat (5 * DIV) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 9'(rdy_7), 9'h0);
        chk("rst_mid_data", 9'(d_7), 9'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_after_rdy", 9'(rdy_7), 9'h0);
        chk("rst_after_data", 9'(d_7), 9'h0);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
